d_mem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer in front of the single-port d_mem.

---
 rtl/d_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_d_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/d_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port d_mem.
// Build option: ARB_FIXED_PRIO_EN makes port A win every tie (B may starve).
//
//   state | meaning
//   IDLE  | no access in flight; arbitrate, answer illegal addresses locally
//   SERV  | owner's access drives d_mem; completes and acks at the closing edge
module d_mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 1024
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              A_Req,
   input  logic [ADDR_W-1:0] A_Addr,
   input  logic [DATA_W-1:0] A_WData,
   input  logic              A_Write,
   output logic              A_Ack,
   output logic [DATA_W-1:0] A_RData,
   output logic              A_Err,
   input  logic              B_Req,
   input  logic [ADDR_W-1:0] B_Addr,
   input  logic [DATA_W-1:0] B_WData,
   input  logic              B_Write,
   output logic              B_Ack,
   output logic [DATA_W-1:0] B_RData,
   output logic              B_Err,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_WriteData,
   output logic              Mem_MemWrite,
   output logic              Mem_MemRead,
   input  logic [DATA_W-1:0] Mem_ReadData
);

   typedef enum logic {IDLE, SERV} state_t;

   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(MEM_WORDS * 4);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;          // 1 = port B
   logic              last_grant_q, last_grant_d; // 1 = port B
   logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic              a_err_q, a_err_d, b_err_q, b_err_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

   logic              a_eff, b_eff, grant_b;
   logic [ADDR_W-1:0] gnt_addr;
   logic              gnt_legal;

`ifdef ARB_FIXED_PRIO_EN
   // A held request streams back-to-back, so B cannot slip in on A's ack cycle.
   assign a_eff   = A_Req;
   assign b_eff   = B_Req & ~b_ack_q;
   assign grant_b = b_eff & ~a_eff;
`else
   assign a_eff   = A_Req & ~a_ack_q;
   assign b_eff   = B_Req & ~b_ack_q;
   assign grant_b = b_eff & (~a_eff | ~last_grant_q);
`endif

   assign gnt_addr  = grant_b ? B_Addr : A_Addr;
   assign gnt_legal = (gnt_addr[1:0] == 2'b00) && (gnt_addr < ADDR_LIM);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         a_err_q      <= 1'b0;
         b_err_q      <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         a_ack_q      <= a_ack_d;
         b_ack_q      <= b_ack_d;
         a_err_q      <= a_err_d;
         b_err_q      <= b_err_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      a_ack_d       = 1'b0;
      b_ack_d       = 1'b0;
      a_err_d       = 1'b0;
      b_err_d       = 1'b0;
      a_rdata_d     = a_rdata_q;
      b_rdata_d     = b_rdata_q;
      Mem_Address   = '0;
      Mem_WriteData = '0;
      Mem_MemWrite  = 1'b0;
      Mem_MemRead   = 1'b0;

      case (state_q)
         IDLE: begin
            if (a_eff | b_eff) begin
               last_grant_d = grant_b;
               if (gnt_legal) begin
                  state_d = SERV;
                  owner_d = grant_b;
               end else if (grant_b) begin
                  b_ack_d = 1'b1;
                  b_err_d = 1'b1;
               end else begin
                  a_ack_d = 1'b1;
                  a_err_d = 1'b1;
               end
            end
         end
         SERV: begin
            Mem_Address   = owner_q ? B_Addr  : A_Addr;
            Mem_WriteData = owner_q ? B_WData : A_WData;
            Mem_MemWrite  = owner_q ? B_Write : A_Write;
            Mem_MemRead   = ~Mem_MemWrite;
            state_d       = IDLE;
            if (owner_q) begin
               b_ack_d = 1'b1;
               if (!B_Write) b_rdata_d = Mem_ReadData;
            end else begin
               a_ack_d = 1'b1;
               if (!A_Write) a_rdata_d = Mem_ReadData;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign A_Ack   = a_ack_q;
   assign A_Err   = a_err_q;
   assign A_RData = a_rdata_q;
   assign B_Ack   = b_ack_q;
   assign B_Err   = b_err_q;
   assign B_RData = b_rdata_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter with a behavioural d_mem (combinational read).
// Expectations switch with ARB_FIXED_PRIO_EN for the contention sequence.
module tb_d_mem_arbiter;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        A_Req = 1'b0, B_Req = 1'b0;
   logic [31:0] A_Addr = '0, B_Addr = '0;
   logic [31:0] A_WData = '0, B_WData = '0;
   logic        A_Write = 1'b0, B_Write = 1'b0;
   logic        A_Ack, A_Err, B_Ack, B_Err;
   logic [31:0] A_RData, B_RData;
   logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
   logic        Mem_MemWrite, Mem_MemRead;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] mem [0:1023];
   bit          no_mem_win = 1'b0;
   bit          mem_hit    = 1'b0;

   d_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .A_Req(A_Req), .A_Addr(A_Addr), .A_WData(A_WData), .A_Write(A_Write),
      .A_Ack(A_Ack), .A_RData(A_RData), .A_Err(A_Err),
      .B_Req(B_Req), .B_Addr(B_Addr), .B_WData(B_WData), .B_Write(B_Write),
      .B_Ack(B_Ack), .B_RData(B_RData), .B_Err(B_Err),
      .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
      .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
      .Mem_ReadData(Mem_ReadData)
   );

   always #5 Clock = ~Clock;

   assign Mem_ReadData = mem[Mem_Address[11:2]];
   always @(posedge Clock) if (Mem_MemWrite) mem[Mem_Address[11:2]] <= Mem_WriteData;

   always @(negedge Clock) if (no_mem_win && (Mem_MemRead || Mem_MemWrite)) mem_hit = 1'b1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // One access from an idle arbiter; checks latency, error flag and (for reads) data.
   task automatic do_acc(input bit port_b, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit wr, input bit exp_err, input logic [31:0] exp_rd,
                         input string tag);
      int lat;
      bit got;
      lat = 0;
      got = 1'b0;
      @(posedge Clock); #1;
      if (port_b) begin
         B_Addr = addr; B_WData = wdata; B_Write = wr; B_Req = 1'b1;
      end else begin
         A_Addr = addr; A_WData = wdata; A_Write = wr; A_Req = 1'b1;
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge Clock); #1;
         lat++;
         if (port_b ? B_Ack : A_Ack) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_ack"}, 32'(got), 32'd1);
      chk({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
      chk({tag, "_err"}, 32'(port_b ? B_Err : A_Err), 32'(exp_err));
      if (!wr) chk({tag, "_rdata"}, port_b ? B_RData : A_RData, exp_rd);
      A_Req = 1'b0;
      B_Req = 1'b0;
   endtask

   logic [1:0] exp3 [8];
   int         a_at, b_at, b_lat;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[10'h3FF] = 32'h1111_2222;

      repeat (2) @(posedge Clock);
      #1;
      chk("rst_a_ack", 32'(A_Ack), 32'd0);
      chk("rst_mem_rd", 32'(Mem_MemRead), 32'd0);
      Reset_n = 1'b1;

      // Write then read back on port A
      do_acc(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, "t2_wr");
      chk("t2_mem", mem[4], 32'hDEAD_BEEF);
      do_acc(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, "t2_rd");

      // Reset asserted in the middle of a write's SERV cycle
      @(posedge Clock); #1;
      A_Addr = 32'h20; A_WData = 32'hAAAA_5555; A_Write = 1'b1; A_Req = 1'b1;
      @(posedge Clock); #1;
      chk("t1_serv_wr", 32'(Mem_MemWrite), 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      chk("t1_memwrite", 32'(Mem_MemWrite), 32'd0);
      chk("t1_acks", {30'd0, A_Ack, B_Ack}, 32'd0);
      chk("t1_a_rdata", A_RData, 32'd0);
      chk("t1_b_rdata", B_RData, 32'd0);
      A_Req = 1'b0; A_Write = 1'b0;
      @(posedge Clock); #1;
      chk("t1_no_commit", mem[8], 32'd0);
      Reset_n = 1'b1;

      // Both ports requesting continuously from reset
`ifdef ARB_FIXED_PRIO_EN
      exp3 = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
`else
      exp3 = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`endif
      @(posedge Clock); #1;
      A_Addr = 32'h10; A_Write = 1'b0; A_Req = 1'b1;
      B_Addr = 32'h10; B_Write = 1'b0; B_Req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge Clock); #1;
         chk($sformatf("t3_acks_c%0d", k + 1), {30'd0, A_Ack, B_Ack}, {30'd0, exp3[k]});
      end
`ifdef ARB_FIXED_PRIO_EN
      A_Req = 1'b0;
      b_lat = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge Clock); #1;
         b_lat++;
         if (B_Ack) break;
      end
      chk("t6_b_lat", 32'(b_lat), 32'd2);
      B_Req = 1'b0;
`else
      A_Req = 1'b0;
      B_Req = 1'b0;
`endif
      chk("t3_b_rdata", B_RData, 32'hDEAD_BEEF);

      // Illegal addresses on port B never reach memory
      no_mem_win = 1'b1;
      do_acc(1'b1, 32'h1002, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "t4_misal");
      do_acc(1'b1, 32'h1000, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, "t4_range");
      @(negedge Clock);
      no_mem_win = 1'b0;
      chk("t4_nomem", 32'(mem_hit), 32'd0);

      // Same-cycle A read / B write to 0xFFC: A first sees the old word
      @(posedge Clock); #1;
      A_Addr = 32'hFFC; A_Write = 1'b0; A_Req = 1'b1;
      B_Addr = 32'hFFC; B_WData = 32'h55; B_Write = 1'b1; B_Req = 1'b1;
      a_at = 0;
      b_at = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge Clock); #1;
         if (A_Ack) begin
            a_at = k;
            chk("t5_a_old", A_RData, 32'h1111_2222);
            A_Req = 1'b0;
         end
         if (B_Ack) begin
            b_at = k;
            B_Req = 1'b0;
         end
      end
      A_Req = 1'b0;
      B_Req = 1'b0;
      chk("t5_a_at", 32'(a_at), 32'd2);
      chk("t5_b_at", 32'(b_at), 32'd4);
      do_acc(1'b0, 32'hFFC, 32'h0, 1'b0, 1'b0, 32'h55, "t5_a_new");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
